// File: rtl/mmss_pkg.sv
// Shared types and constants for the MM:SS BCD timer.
package mmss_pkg;

   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned N_DIGITS  = 4;
   localparam int unsigned SEC_U_MAX = 9;
   localparam int unsigned SEC_T_MAX = 5;
   localparam int unsigned MIN_U_MAX = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   typedef struct packed {
      logic [DIGIT_W-1:0] min_t;
      logic [DIGIT_W-1:0] min_u;
      logic [DIGIT_W-1:0] sec_t;
      logic [DIGIT_W-1:0] sec_u;
   } bcd_t;

   // True when every digit of v lies within its modulus.
   function automatic logic bcd_in_range(input bcd_t v, input logic [DIGIT_W-1:0] min_t_max);
      return (v.sec_u <= DIGIT_W'(SEC_U_MAX)) &&
             (v.sec_t <= DIGIT_W'(SEC_T_MAX)) &&
             (v.min_u <= DIGIT_W'(MIN_U_MAX)) &&
             (v.min_t <= min_t_max);
   endfunction

endpackage : mmss_pkg

// File: rtl/mmss_timer_if.sv
// Control/status bundle between a timer client and mmss_timer.
interface mmss_timer_if;
   import mmss_pkg::*;

   logic tick_en;
   logic start;
   logic stop;
   logic clear;
   logic load;
   bcd_t load_value;
   logic dir;
   bcd_t digits;
   logic running;
   logic done;
   logic wrap;
   logic load_err;

   modport master (
      output tick_en, start, stop, clear, load, load_value, dir,
      input  digits, running, done, wrap, load_err
   );

   modport slave (
      input  tick_en, start, stop, clear, load, load_value, dir,
      output digits, running, done, wrap, load_err
   );

endinterface : mmss_timer_if

// File: rtl/mod_digit.sv
// One BCD digit with a programmable modulus (0..max_i), up/down stepping and load.
module mod_digit
   import mmss_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic               dir_i,
   input  logic               ld_i,
   input  logic [DIGIT_W-1:0] ld_val_i,
   input  logic [DIGIT_W-1:0] max_i,
   output logic [DIGIT_W-1:0] q_o,
   output logic               carry_c_o,
   output logic               borrow_c_o
);

   logic [DIGIT_W-1:0] q_q;
   logic [DIGIT_W-1:0] q_d;

   // Load wins over stepping; dir_i=1 counts down.
   always_comb begin
      q_d = q_q;
      if (ld_i) begin
         q_d = ld_val_i;
      end else if (en_i) begin
         if (dir_i) begin
            q_d = (q_q == '0) ? max_i : q_q - DIGIT_W'(1);
         end else begin
            q_d = (q_q == max_i) ? '0 : q_q + DIGIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o        = q_q;
   assign carry_c_o  = (q_q == max_i);
   assign borrow_c_o = (q_q == '0);

endmodule : mod_digit

// File: rtl/mmss_timer.sv
// MM:SS BCD up/down timer: request-priority FSM driving a chain of four digits.
module mmss_timer
   import mmss_pkg::*;
#(
   parameter int unsigned MIN_T_MAX = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   mmss_timer_if.slave  bus
);

   state_e state_q;
   state_e state_d;

   logic running_q, running_d;
   logic done_q, done_d;
   logic wrap_q, wrap_d;
   logic load_err_q, load_err_d;

   logic ld_c;
   bcd_t ld_val_c;
   logic step_c;

   logic [N_DIGITS-1:0] en_c;
   logic [N_DIGITS-1:0] carry_c;
   logic [N_DIGITS-1:0] borrow_c;
   logic [DIGIT_W-1:0]  q_c   [N_DIGITS];
   logic [DIGIT_W-1:0]  max_c [N_DIGITS];

   bcd_t cnt_c;
   logic all_max_c;
   logic is_one_c;
   logic is_zero_c;

   assign max_c[0] = DIGIT_W'(SEC_U_MAX);
   assign max_c[1] = DIGIT_W'(SEC_T_MAX);
   assign max_c[2] = DIGIT_W'(MIN_U_MAX);
   assign max_c[3] = DIGIT_W'(MIN_T_MAX);

   assign cnt_c     = {q_c[3], q_c[2], q_c[1], q_c[0]};
   assign all_max_c = &carry_c;
   assign is_zero_c = &borrow_c;
   assign is_one_c  = (q_c[0] == DIGIT_W'(1)) && (&borrow_c[N_DIGITS-1:1]);

   // Ripple enable: a digit steps when all lower digits carry (up) or borrow (down).
   always_comb begin
      en_c[0] = step_c;
      for (int i = 1; i < int'(N_DIGITS); i++) begin
         en_c[i] = en_c[i-1] & (bus.dir ? borrow_c[i-1] : carry_c[i-1]);
      end
   end

   for (genvar g = 0; g < int'(N_DIGITS); g++) begin : g_digit
      mod_digit u_digit (
         .clk        (clk),
         .rst_n      (reset_n),
         .en_i       (en_c[g]),
         .dir_i      (bus.dir),
         .ld_i       (ld_c),
         .ld_val_i   (ld_val_c[g*DIGIT_W +: DIGIT_W]),
         .max_i      (max_c[g]),
         .q_o        (q_c[g]),
         .carry_c_o  (carry_c[g]),
         .borrow_c_o (borrow_c[g])
      );
   end

   // Request arbitration: clear > load > stop > start > tick_en.
   always_comb begin
      state_d    = state_q;
      ld_c       = 1'b0;
      ld_val_c   = '0;
      step_c     = 1'b0;
      done_d     = 1'b0;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;

      if (bus.clear) begin
         state_d = ST_IDLE;
         ld_c    = 1'b1;
      end else if (bus.load && (state_q != ST_RUN)) begin
         if (bcd_in_range(bus.load_value, max_c[3])) begin
            ld_c     = 1'b1;
            ld_val_c = bus.load_value;
            state_d  = ST_IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (bus.stop) begin
         if (state_q == ST_RUN) begin
            state_d = ST_IDLE;
         end
      end else if (bus.start && (state_q != ST_RUN)) begin
         if ((state_q == ST_IDLE) && !(bus.dir && is_zero_c)) begin
            state_d = ST_RUN;
         end else if ((state_q == ST_EXPIRED) && !bus.dir) begin
            state_d = ST_RUN;
         end
      end else if (bus.tick_en && (state_q == ST_RUN)) begin
         step_c = 1'b1;
         if (bus.dir) begin
            if (is_one_c) begin
               done_d  = 1'b1;
               state_d = ST_EXPIRED;
            end
         end else begin
            wrap_d = all_max_c;
         end
      end

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         running_q  <= running_d;
         done_q     <= done_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.digits   = cnt_c;
   assign bus.running  = running_q;
   assign bus.done     = done_q;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = load_err_q;

endmodule : mmss_timer

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 Parameter MIN_T_MAX, default 5: maximum value of the minutes-tens digit, legal range 1..9.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 tick_en  input  1  one-cycle count-step qualifier from the upstream prescaler.
REQ-005 start  input  1  request counting.
REQ-006 stop  input  1  request pause.
REQ-007 clear  input  1  zero the digits and return to IDLE.
REQ-008 load  input  1  load load_value into the digits.
REQ-009 load_value  input  16  BCD value {min_t, min_u, sec_t, sec_u}, 4 bits each.
REQ-010 dir  input  1  count direction: 0 = up, 1 = down.
REQ-011 digits  output  16  current BCD count {min_t, min_u, sec_t, sec_u}.
REQ-012 running  output  1  high while state is RUN.
REQ-013 done  output  1  one-cycle pulse when a down-count reaches 00:00.
REQ-014 wrap  output  1  one-cycle pulse when an up-count rolls over from MIN_T_MAX9:59 to 00:00.
REQ-015 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and EXPIRED.
REQ-017 Digit moduli SHALL be: sec_u mod 10, sec_t mod 6, min_u mod 10, min_t mod (MIN_T_MAX+1).
REQ-018 Request priority within a cycle SHALL be clear > load > stop > start > tick_en.
REQ-019 clear, in any state, SHALL set digits to 0, enter IDLE, and suppress every other request in that cycle.
REQ-020 load SHALL be accepted only in IDLE or EXPIRED, and only when every digit is within its modulus; acceptance updates digits on the next edge and enters IDLE.
REQ-021 load SHALL be ignored in RUN and SHALL NOT pulse load_err there.
REQ-022 A load with any out-of-range digit SHALL leave digits unchanged and pulse load_err for one cycle.
REQ-023 start in IDLE SHALL enter RUN, except when dir=1 and digits==0000, in which case start is ignored.
REQ-024 start in EXPIRED with dir=0 SHALL enter RUN.
REQ-025 stop in RUN SHALL enter IDLE with digits held; a start in the same cycle is ignored.
REQ-026 In RUN, each cycle with tick_en=1 SHALL step the count exactly once on that edge, with zero extra latency.
REQ-027 tick_en SHALL be ignored outside RUN and in any cycle where a higher-priority request acts.
REQ-028 Up-count: a digit at its maximum wraps to 0 and carries into the next digit.
REQ-029 Up-count: rollover of the full value to 0000 SHALL assert wrap in the same cycle that digits show 0000, and the block stays in RUN.
REQ-030 Down-count: a digit at 0 wraps to its maximum and borrows from the next digit.
REQ-031 Down-count: reaching 0000 SHALL enter EXPIRED and assert done in the same cycle that digits show 0000.
REQ-032 dir SHALL be sampled on every tick; changing direction mid-run is legal.
REQ-033 EXPIRED SHALL hold 0000 with running=0 until clear, load, or an up-direction start.
REQ-034 done, wrap and load_err SHALL be registered outputs, high for exactly one cycle per event.

Reset
REQ-035 Asserting reset_n low SHALL immediately force IDLE, digits=0000, running=0, done=0, wrap=0 and load_err=0, independent of clk.
REQ-036 Reset asserted mid-count SHALL discard the count; the first edge after release behaves as IDLE.

Structure
REQ-037 Package mmss_pkg SHALL hold the state enum, the BCD digit width (4), and the per-digit maxima constants for sec_u, sec_t and min_u.
REQ-038 Sub-module mod_digit SHALL implement one programmable-modulus BCD digit with inputs en, dir, ld, ld_val, max and outputs q, carry, borrow.
REQ-039 mmss_timer SHALL instantiate four mod_digit instances plus the FSM.

Verification
REQ-040 Reset, load 0x0958, start, dir=0, 3 ticks -> digits 0x0959, 0x1000, 0x1001; wrap=0 throughout.
REQ-041 Load 0x5959, dir=0, start, 1 tick -> digits 0x0000, wrap pulses 1 cycle, running stays 1.
REQ-042 Load 0x0002, dir=1, start, 2 ticks -> digits 0x0001 then 0x0000, done pulses 1 cycle, state EXPIRED, further ticks leave 0x0000.
REQ-043 Load 0x0070 (sec_t=7) -> load_err pulses 1 cycle, digits unchanged; load 0x1234 while RUN -> ignored, no load_err.
REQ-044 In RUN, assert stop+start+tick_en in the same cycle -> IDLE with digits held; assert clear+load together -> digits 0x0000, IDLE.
REQ-045 Assert reset_n low between clock edges mid-count -> outputs 0 and IDLE immediately, before the next edge.
